// File: rtl/matrix_seq_ctrl.sv
// Control FSM for the heavyhash matrix-vector multiplier: matrix load, multiply, drain, output.
// Optional counters hash_count/stall_count enabled by defining MATRIX_SEQ_PERF_EN.
module matrix_seq_ctrl #(
  parameter int unsigned N_COLS     = 64,
  parameter int unsigned LOAD_DEPTH = 16,
  parameter int unsigned HASH_WORDS = 16,
  parameter int unsigned OUT_WORDS  = 4,
  parameter int unsigned PE_LAT     = 4,
  localparam int unsigned LD_W      = $clog2(LOAD_DEPTH),
  localparam int unsigned HW_W      = $clog2(HASH_WORDS),
  localparam int unsigned ADDR_RAW  = (LD_W > HW_W) ? LD_W : HW_W,
  localparam int unsigned ADDR_W    = (ADDR_RAW > 0) ? ADDR_RAW : 1,
  localparam int unsigned OUT_W     = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_empty,
  input  logic              hashin_empty,
  input  logic              fifo_full,
  output logic              m_re,
  output logic              m_ram_we,
  output logic [N_COLS-1:0] en_column,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              addr_sel,
  output logic              hashin_re,
  output logic              PE_en,
  output logic              PE_clr,
  output logic              hashout_we,
  output logic [OUT_W-1:0]  out_idx,
  output logic              matrix_valid,
  output logic              busy
`ifdef MATRIX_SEQ_PERF_EN
  ,
  output logic [31:0]       hash_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned DRN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MULT  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_j;
  logic [DRN_W-1:0]  r_drain;
  logic [OUT_W-1:0]  r_t;
  logic              r_matrix_valid;
  logic              r_addr_sel;
  logic              w_stall;

  // State and counters; counters only advance on cycles whose strobe actually fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_col          <= '0;
      r_j            <= '0;
      r_drain        <= '0;
      r_t            <= '0;
      r_matrix_valid <= 1'b0;
      r_addr_sel     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!m_empty) begin
            r_state        <= S_LOAD;
            r_row          <= '0;
            r_col          <= '0;
            r_matrix_valid <= 1'b0;
            r_addr_sel     <= 1'b0;
          end else if (!hashin_empty && r_matrix_valid) begin
            r_state    <= S_MULT;
            r_j        <= '0;
            r_addr_sel <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!m_empty) begin
            if (r_row == ADDR_W'(LOAD_DEPTH - 1)) begin
              r_row <= '0;
              r_col <= r_col + COL_W'(1);
              if (r_col == COL_W'(N_COLS - 1)) begin
                r_matrix_valid <= 1'b1;
                r_state        <= S_IDLE;
              end
            end else begin
              r_row <= r_row + ADDR_W'(1);
            end
          end
        end
        S_MULT: begin
          if (!hashin_empty) begin
            r_j <= r_j + ADDR_W'(1);
            if (r_j == ADDR_W'(HASH_WORDS - 1)) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == DRN_W'(PE_LAT - 1)) begin
            r_state <= S_OUT;
            r_t     <= '0;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        S_OUT: begin
          if (!fifo_full) begin
            r_t <= r_t + OUT_W'(1);
            if (r_t == OUT_W'(OUT_WORDS - 1)) begin
              r_state    <= S_IDLE;
              r_addr_sel <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Same-cycle strobe decode from state and FIFO flags.
  always_comb begin
    m_re       = 1'b0;
    m_ram_we   = 1'b0;
    en_column  = '0;
    ram_addr   = '0;
    hashin_re  = 1'b0;
    PE_en      = 1'b0;
    PE_clr     = 1'b0;
    hashout_we = 1'b0;
    out_idx    = '0;
    w_stall    = 1'b0;
    case (r_state)
      S_IDLE: PE_clr = 1'b1;
      S_LOAD: begin
        ram_addr = r_row;
        w_stall  = m_empty;
        if (!m_empty) begin
          m_re      = 1'b1;
          m_ram_we  = 1'b1;
          en_column = N_COLS'(1) << r_col;
        end
      end
      S_MULT: begin
        ram_addr = r_j;
        w_stall  = hashin_empty;
        if (!hashin_empty) begin
          hashin_re = 1'b1;
          PE_en     = 1'b1;
          en_column = '1;
        end
      end
      S_DRAIN: PE_en = 1'b1;
      S_OUT: begin
        out_idx    = r_t;
        w_stall    = fifo_full;
        hashout_we = !fifo_full;
      end
      default: ;
    endcase
  end

  assign matrix_valid = r_matrix_valid;
  assign addr_sel     = r_addr_sel;
  assign busy         = (r_state != S_IDLE);

`ifdef MATRIX_SEQ_PERF_EN
  // Result and stall counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hashout_we && (r_t == OUT_W'(OUT_WORDS - 1))) hash_count <= hash_count + 32'd1;
      if (w_stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Self-checking bench for matrix_seq_ctrl using a transaction-level reference of each phase.
module tb_matrix_seq_ctrl;
  localparam int NC = 4;
  localparam int LD = 2;
  localparam int HW = 3;
  localparam int OW = 2;
  localparam int PL = 2;
  localparam int TOTAL = NC * LD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_empty = 1'b1;
  logic hashin_empty = 1'b1;
  logic fifo_full = 1'b0;
  logic m_re, m_ram_we, addr_sel, hashin_re, PE_en, PE_clr, hashout_we, matrix_valid, busy;
  logic [NC-1:0] en_column;
  logic [1:0] ram_addr;
  logic [0:0] out_idx;
`ifdef MATRIX_SEQ_PERF_EN
  logic [31:0] hash_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int model_hash = 0;
  int model_stall = 0;

  logic [6:0] obs;
  assign obs = {m_re, m_ram_we, hashin_re, PE_en, PE_clr, hashout_we, busy};

  matrix_seq_ctrl #(
    .N_COLS(NC), .LOAD_DEPTH(LD), .HASH_WORDS(HW), .OUT_WORDS(OW), .PE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_empty(m_empty), .hashin_empty(hashin_empty),
    .fifo_full(fifo_full), .m_re(m_re), .m_ram_we(m_ram_we), .en_column(en_column),
    .ram_addr(ram_addr), .addr_sel(addr_sel), .hashin_re(hashin_re), .PE_en(PE_en),
    .PE_clr(PE_clr), .hashout_we(hashout_we), .out_idx(out_idx),
    .matrix_valid(matrix_valid), .busy(busy)
`ifdef MATRIX_SEQ_PERF_EN
    , .hash_count(hash_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_perf(input string tag);
`ifdef MATRIX_SEQ_PERF_EN
    checks++;
    if (hash_count !== 32'(model_hash)) begin
      errors++;
      $display("FAIL %s hash_count: got %0d expected %0d", tag, hash_count, model_hash);
    end
    checks++;
    if (stall_count !== 32'(model_stall)) begin
      errors++;
      $display("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, model_stall);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Idle decode after reset: only PE_clr, nothing resident.
  task automatic test_reset();
    rst_n = 1'b0; m_empty = 1'b1; hashin_empty = 1'b1; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_hash = 0; model_stall = 0;
    @(negedge clk);
    checks++;
    if (obs !== 7'b0000100 || en_column !== '0 || matrix_valid !== 1'b0 || addr_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset: got obs=%b en=%b mv=%b as=%b expected obs=0000100 en=0 mv=0 as=0",
               obs, en_column, matrix_valid, addr_sel);
    end
    check_perf("reset");
  endtask

  // Hash-in present without a matrix must never start a multiply.
  task automatic test_no_matrix();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 hashin_empty = 1'b0; m_empty = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 7'b0000100 || matrix_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_matrix cyc %0d: got obs=%b mv=%b expected obs=0000100 mv=0", c, obs, matrix_valid);
      end
    end
    @(posedge clk); #1 hashin_empty = 1'b1;
  endtask

  // Full matrix load with random M-FIFO starvation.
  task automatic test_load(input int stall_pct);
    int k = 0;
    int cyc = 0;
    bit loading = 0;
    logic [6:0] exp_s;
    logic [NC-1:0] exp_en;
    logic [NC-1:0] one = 1;
    hashin_empty = 1'b1; fifo_full = 1'b0;
    while (k < TOTAL && cyc < 500) begin
      @(posedge clk); #1;
      m_empty = loading ? ($urandom_range(99) < stall_pct) : 1'b0;
      @(negedge clk); cyc++;
      if (!loading) begin
        exp_s = 7'b0000100; exp_en = '0; loading = 1;
      end else if (!m_empty) begin
        exp_s = 7'b1100001; exp_en = one << (k / LD);
        checks++;
        if (ram_addr !== 2'(k % LD) || addr_sel !== 1'b0) begin
          errors++;
          $display("FAIL load addr k=%0d: got addr=%0d sel=%b expected addr=%0d sel=0", k, ram_addr, addr_sel, k % LD);
        end
        k++;
      end else begin
        exp_s = 7'b0000001; exp_en = '0; model_stall++;
      end
      checks++;
      if (obs !== exp_s || en_column !== exp_en) begin
        errors++;
        $display("FAIL load strobes k=%0d: got obs=%b en=%b expected obs=%b en=%b", k, obs, en_column, exp_s, exp_en);
      end
    end
    @(posedge clk); #1 m_empty = 1'b1;
    @(negedge clk);
    checks++;
    if (k !== TOTAL || matrix_valid !== 1'b1 || obs !== 7'b0000100) begin
      errors++;
      $display("FAIL load end: got writes=%0d mv=%b obs=%b expected writes=%0d mv=1 obs=0000100", k, matrix_valid, obs, TOTAL);
    end
    check_perf("load");
  endtask

  // One multiply with random hash-in starvation and hashout back-pressure.
  task automatic test_multiply(input int in_pct, input int full_pct);
    int ph = 0;
    int r = 0;
    int d = 0;
    int w = 0;
    int cyc = 0;
    logic [6:0] exp_s;
    logic [NC-1:0] exp_en;
    m_empty = 1'b1;
    while (ph < 4 && cyc < 300) begin
      @(posedge clk); #1;
      hashin_empty = (ph == 0) ? 1'b0 : ($urandom_range(99) < in_pct);
      fifo_full = ($urandom_range(99) < full_pct);
      @(negedge clk); cyc++;
      exp_en = '0;
      checks++;
      if (addr_sel !== (ph != 0)) begin
        errors++;
        $display("FAIL mult addr_sel ph=%0d: got %b expected %b", ph, addr_sel, ph != 0);
      end
      case (ph)
        0: begin exp_s = 7'b0000100; ph = 1; end
        1: begin
          if (!hashin_empty) begin
            exp_s = 7'b0011001; exp_en = '1;
            checks++;
            if (ram_addr !== 2'(r)) begin
              errors++;
              $display("FAIL mult ram_addr: got %0d expected %0d", ram_addr, r);
            end
            r++;
            if (r == HW) ph = 2;
          end else begin
            exp_s = 7'b0000001; model_stall++;
          end
        end
        2: begin
          exp_s = 7'b0001001; d++;
          if (d == PL) ph = 3;
        end
        default: begin
          checks++;
          if (out_idx !== 1'(w)) begin
            errors++;
            $display("FAIL mult out_idx: got %0d expected %0d", out_idx, w);
          end
          if (!fifo_full) begin
            exp_s = 7'b0000011; w++;
            if (w == OW) begin ph = 4; model_hash++; end
          end else begin
            exp_s = 7'b0000001; model_stall++;
          end
        end
      endcase
      checks++;
      if (obs !== exp_s || en_column !== exp_en) begin
        errors++;
        $display("FAIL mult strobes cyc %0d: got obs=%b en=%b expected obs=%b en=%b", cyc, obs, en_column, exp_s, exp_en);
      end
    end
    @(posedge clk); #1 hashin_empty = 1'b1; fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (ph !== 4 || obs !== 7'b0000100 || addr_sel !== 1'b0 || matrix_valid !== 1'b1) begin
      errors++;
      $display("FAIL mult end: got done=%0d obs=%b sel=%b mv=%b expected done=1 obs=0000100 sel=0 mv=1",
               ph == 4, obs, addr_sel, matrix_valid);
    end
    if (in_pct == 0 && full_pct == 0) begin
      checks++;
      if (cyc !== 1 + HW + PL + OW) begin
        errors++;
        $display("FAIL mult latency: got %0d expected %0d", cyc, 1 + HW + PL + OW);
      end
    end
    check_perf("mult");
  endtask

  // Asynchronous reset part-way through a load abandons the matrix.
  task automatic test_load_abort();
    @(posedge clk); #1 m_empty = 1'b0; hashin_empty = 1'b1; fifo_full = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (m_re !== 1'b1 || matrix_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort pre: got m_re=%b mv=%b expected m_re=1 mv=0", m_re, matrix_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000100 || en_column !== '0 || matrix_valid !== 1'b0 || addr_sel !== 1'b0) begin
      errors++;
      $display("FAIL abort: got obs=%b en=%b mv=%b expected obs=0000100 en=0 mv=0", obs, en_column, matrix_valid);
    end
    m_empty = 1'b1;
    model_hash = 0; model_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_perf("abort");
  endtask

  initial begin
    test_reset();
    test_no_matrix();
    test_load(0);
    test_multiply(0, 0);
    for (int i = 0; i < 4; i++) test_multiply(40, 40);
    test_load(40);
    test_multiply(30, 50);
    test_multiply(0, 0);
    test_load_abort();
    test_load(0);
    test_multiply(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_seq_ctrl.md
Name: matrix_seq_ctrl

Overview:
Parametrised control FSM for the heavyhash matrix-vector multiplier. It loads an N_COLS x LOAD_DEPTH matrix from the M FIFO into per-column block RAMs, then streams hash-in words through the PE array. It drains the PE pipeline and writes result words to the hashout FIFO. Unlike its fixed-size predecessor, it owns the i/k/j/t counters internally, tracks matrix validity, and stalls cleanly on FIFO empty/full.

Parameters:
N_COLS, 64, number of column RAMs / PE columns
LOAD_DEPTH, 16, M-FIFO words written per column during load
HASH_WORDS, 16, hash-in words consumed per multiply
OUT_WORDS, 4, hashout words emitted per multiply
PE_LAT, 4, PE pipeline latency in cycles (>=1)

Ports:
clk  in  1  global clock
rst_n  in  1  reset; one clock, asynchronous assert, active-low
m_empty  in  1  M FIFO empty
hashin_empty  in  1  hash-in FIFO empty
fifo_full  in  1  hashout FIFO full
m_re  out  1  M FIFO read strobe
m_ram_we  out  1  matrix RAM write enable
en_column  out  N_COLS  column RAM enables
ram_addr  out  max($clog2(LOAD_DEPTH),$clog2(HASH_WORDS))  matrix RAM address (row in load, j in multiply)
addr_sel  out  1  0 = load addressing, 1 = multiply addressing
hashin_re  out  1  hash-in FIFO read strobe
PE_en  out  1  PE pipeline enable
PE_clr  out  1  PE accumulator clear
hashout_we  out  1  hashout FIFO write strobe
out_idx  out  $clog2(OUT_WORDS) (min 1)  index of word being written
matrix_valid  out  1  complete matrix resident in RAM
busy  out  1  state != IDLE

Behaviour:
- Registered state and counters row, col, j, drain, t. Strobes are combinational decodes of state and FIFO flags (same-cycle response).
- Reset: state=IDLE; all counters=0; matrix_valid=0; addr_sel=0. All strobes 0 except PE_clr=1 (IDLE decode).
- IDLE:
  - PE_clr=1.
  - !m_empty -> M_LOAD; row=col=0; matrix_valid<=0; addr_sel<=0. Matrix load has priority.
  - Else if !hashin_empty && matrix_valid -> MULT; j=0; addr_sel<=1.
  - Hash-in present with matrix_valid=0: remain in IDLE, no strobes.
- M_LOAD, cycle with !m_empty:
  - m_re=1, m_ram_we=1, en_column=one-hot(col), ram_addr=row.
  - row==LOAD_DEPTH-1: row<=0, col<=col+1.
  - row==LOAD_DEPTH-1 and col==N_COLS-1: matrix_valid<=1, -> IDLE.
- M_LOAD, cycle with m_empty: stall; all strobes 0; counters hold.
- MULT, cycle with !hashin_empty:
  - hashin_re=1, PE_en=1, en_column=all ones, ram_addr=j, j<=j+1.
  - j==HASH_WORDS-1: -> DRAIN, drain<=0.
- MULT, cycle with hashin_empty: hashin_re=0, PE_en=0 (pipeline frozen), en_column=0; j holds.
- DRAIN: PE_en=1 for exactly PE_LAT cycles. On drain==PE_LAT-1 -> OUTPUT, t<=0.
- OUTPUT:
  - Cycle with !fifo_full: hashout_we=1, out_idx=t, t<=t+1.
  - t==OUTPUT-end, i.e. t==OUTPUT_WORDS-1 (OUT_WORDS-1): -> IDLE, addr_sel<=0.
  - fifo_full: hashout_we=0; t holds; out_idx still shows t.
- matrix_valid persists across multiplies and is cleared only by a new load or reset. A matrix load never interrupts MULT/DRAIN/OUTPUT.
- Reset mid-operation aborts immediately, abandons partial load/result, matrix_valid=0.
- PE_en is 0 in IDLE, M_LOAD and OUTPUT.
- Throughput: N_COLS*LOAD_DEPTH load cycles. HASH_WORDS+PE_LAT+OUT_WORDS cycles per hash, plus 1 IDLE cycle, with no stalls.

Optional Feature:
MATRIX_SEQ_PERF_EN:
- Defined: adds outputs hash_count[31:0] (increments on the last hashout_we of each result) and stall_count[31:0] (increments each cycle in M_LOAD/MULT/OUTPUT with a strobe suppressed by empty/full). Both wrap at 2^32 and are reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
All scenarios use N_COLS=4, LOAD_DEPTH=2, HASH_WORDS=3, OUT_WORDS=2, PE_LAT=2.
- Reset, m_empty=0 continuous -> 8 m_re/m_ram_we cycles; en_column 0001,0001,0010,0010,...,1000; ram_addr 0,1,0,1...; matrix_valid=1 after 8th; back to IDLE.
- After load, hashin_empty=0, fifo_full=0 -> hashin_re 3 cycles (ram_addr 0,1,2), PE_en 5 consecutive cycles, hashout_we 2 cycles (out_idx 0,1), then IDLE with PE_clr=1.
- Hash-in available with matrix_valid=0 after reset -> no hashin_re/PE_en for 20 cycles; busy=0.
- hashin_empty pulsed high 2 cycles after 1st MULT read -> PE_en=0 and j held during the gap; exactly 3 total hashin_re; the result is still 2 writes.
- fifo_full high for 3 cycles during OUTPUT word 0 -> hashout_we=0 with out_idx=0 held; then out_idx 0,1 written.
- rst_n low mid-M_LOAD (after 5 writes) -> all strobes 0 asynchronously, matrix_valid=0; a subsequent full load succeeds. With MATRIX_SEQ_PERF_EN defined, after one hash: hash_count=1.
